// File: rtl/panda_risc_v_reg_file_rd_arb_if.sv
// Register-file read arbitration bus: decoder read ports, aux reader and physical ports.
// REG_FILE_RD_ARB_STAT_EN adds the stall/preempt statistics counters.
interface panda_risc_v_reg_file_rd_arb_if;
  logic        dcd_reg_file_rd_p0_req;
  logic [4:0]  dcd_reg_file_rd_p0_addr;
  logic        dcd_reg_file_rd_p0_grant;
  logic [31:0] dcd_reg_file_rd_p0_dout;
  logic        dcd_reg_file_rd_p1_req;
  logic [4:0]  dcd_reg_file_rd_p1_addr;
  logic        dcd_reg_file_rd_p1_grant;
  logic [31:0] dcd_reg_file_rd_p1_dout;
  logic        aux_reg_file_rd_req;
  logic [4:0]  aux_reg_file_rd_addr;
  logic        aux_reg_file_rd_grant;
  logic [31:0] aux_reg_file_rd_dout;
  logic [4:0]  reg_file_rd_p0_addr;
  logic [31:0] reg_file_rd_p0_dout;
  logic [4:0]  reg_file_rd_p1_addr;
  logic [31:0] reg_file_rd_p1_dout;
`ifdef REG_FILE_RD_ARB_STAT_EN
  logic [15:0] aux_stall_cnt;
  logic [15:0] dcd_p1_preempt_cnt;
`endif

  modport slave (
    input  dcd_reg_file_rd_p0_req, dcd_reg_file_rd_p0_addr,
    output dcd_reg_file_rd_p0_grant, dcd_reg_file_rd_p0_dout,
    input  dcd_reg_file_rd_p1_req, dcd_reg_file_rd_p1_addr,
    output dcd_reg_file_rd_p1_grant, dcd_reg_file_rd_p1_dout,
    input  aux_reg_file_rd_req, aux_reg_file_rd_addr,
    output aux_reg_file_rd_grant, aux_reg_file_rd_dout,
    output reg_file_rd_p0_addr, reg_file_rd_p1_addr,
    input  reg_file_rd_p0_dout, reg_file_rd_p1_dout
`ifdef REG_FILE_RD_ARB_STAT_EN
    , output aux_stall_cnt, dcd_p1_preempt_cnt
`endif
  );

  modport master (
    output dcd_reg_file_rd_p0_req, dcd_reg_file_rd_p0_addr,
    input  dcd_reg_file_rd_p0_grant, dcd_reg_file_rd_p0_dout,
    output dcd_reg_file_rd_p1_req, dcd_reg_file_rd_p1_addr,
    input  dcd_reg_file_rd_p1_grant, dcd_reg_file_rd_p1_dout,
    output aux_reg_file_rd_req, aux_reg_file_rd_addr,
    input  aux_reg_file_rd_grant, aux_reg_file_rd_dout,
    input  reg_file_rd_p0_addr, reg_file_rd_p1_addr,
    output reg_file_rd_p0_dout, reg_file_rd_p1_dout
`ifdef REG_FILE_RD_ARB_STAT_EN
    , input aux_stall_cnt, dcd_p1_preempt_cnt
`endif
  );
endinterface

// File: rtl/panda_risc_v_reg_file_rd_arb.sv
// Shares the two physical register-file read ports between decoder RS1/RS2 and an aux reader,
// with a starvation FSM forcing aux onto port 1. Optional statistics: REG_FILE_RD_ARB_STAT_EN.
module panda_risc_v_reg_file_rd_arb #(
  parameter int simulation_delay = 1,
  parameter int STARVE_TH        = 4
) (
  input  logic clk,
  input  logic rst,
  panda_risc_v_reg_file_rd_arb_if.slave bus
);

  typedef enum logic [0:0] {
    ST_NORMAL  = 1'b0,
    ST_STARVED = 1'b1
  } arb_state_t;

  localparam logic [3:0] TH_S    = 4'(STARVE_TH);
  localparam logic [3:0] TH_M1_S = 4'(STARVE_TH - 1);

  if ((STARVE_TH < 1) || (STARVE_TH > 15) || (simulation_delay < 0)) begin : g_bad_param
    $error("panda_risc_v_reg_file_rd_arb: illegal parameter value");
  end

  arb_state_t state_r;
  arb_state_t state_nxt_s;
  logic [3:0] aux_wait_cnt_r;
  logic [3:0] aux_wait_cnt_nxt_s;
  logic       aux_on_p0_s;
  logic       aux_on_p1_s;
  logic       aux_grant_s;
  logic       aux_lose_s;
  logic       dcd_p0_grant_s;
  logic       dcd_p1_grant_s;

  // Same-cycle ownership of the physical ports; nothing is granted while in reset.
  always_comb begin
    aux_on_p0_s = 1'b0;
    aux_on_p1_s = 1'b0;
    if (rst) begin
      aux_on_p0_s = 1'b0;
    end else if (bus.aux_reg_file_rd_req) begin
      if (state_r == ST_STARVED) begin
        aux_on_p1_s = 1'b1;
      end else if (!bus.dcd_reg_file_rd_p0_req) begin
        aux_on_p0_s = 1'b1;
      end else if (!bus.dcd_reg_file_rd_p1_req) begin
        aux_on_p1_s = 1'b1;
      end else begin
        aux_on_p1_s = 1'b0;
      end
    end else begin
      aux_on_p0_s = 1'b0;
    end
    aux_grant_s    = aux_on_p0_s | aux_on_p1_s;
    aux_lose_s     = bus.aux_reg_file_rd_req & ~aux_grant_s;
    dcd_p0_grant_s = ~rst & bus.dcd_reg_file_rd_p0_req;
    dcd_p1_grant_s = ~rst & bus.dcd_reg_file_rd_p1_req & ~aux_on_p1_s;
  end

  assign bus.dcd_reg_file_rd_p0_grant = dcd_p0_grant_s;
  assign bus.dcd_reg_file_rd_p1_grant = dcd_p1_grant_s;
  assign bus.aux_reg_file_rd_grant    = aux_grant_s;
  // Unowned ports fall back to the decoder address to keep decoder paths short.
  assign bus.reg_file_rd_p0_addr = aux_on_p0_s ? bus.aux_reg_file_rd_addr : bus.dcd_reg_file_rd_p0_addr;
  assign bus.reg_file_rd_p1_addr = aux_on_p1_s ? bus.aux_reg_file_rd_addr : bus.dcd_reg_file_rd_p1_addr;
  assign bus.dcd_reg_file_rd_p0_dout = bus.reg_file_rd_p0_dout;
  assign bus.dcd_reg_file_rd_p1_dout = bus.reg_file_rd_p1_dout;
  assign bus.aux_reg_file_rd_dout    = aux_on_p0_s ? bus.reg_file_rd_p0_dout :
                                       (aux_on_p1_s ? bus.reg_file_rd_p1_dout : 32'h0000_0000);

  // Starvation FSM and wait counter next-state logic.
  always_comb begin
    state_nxt_s        = state_r;
    aux_wait_cnt_nxt_s = aux_wait_cnt_r;
    case (state_r)
      ST_NORMAL: begin
        if (aux_lose_s) begin
          if (aux_wait_cnt_r == TH_M1_S) begin
            state_nxt_s        = ST_STARVED;
            aux_wait_cnt_nxt_s = TH_S;
          end else begin
            aux_wait_cnt_nxt_s = aux_wait_cnt_r + 4'd1;
          end
        end else begin
          aux_wait_cnt_nxt_s = 4'd0;
        end
      end
      ST_STARVED: begin
        state_nxt_s        = ST_NORMAL;
        aux_wait_cnt_nxt_s = 4'd0;
      end
      default: begin
        state_nxt_s        = ST_NORMAL;
        aux_wait_cnt_nxt_s = 4'd0;
      end
    endcase
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_NORMAL;
      aux_wait_cnt_r <= 4'd0;
    end else begin
      state_r        <= state_nxt_s;
      aux_wait_cnt_r <= aux_wait_cnt_nxt_s;
    end
  end

`ifdef REG_FILE_RD_ARB_STAT_EN
  logic [15:0] aux_stall_cnt_r;
  logic [15:0] dcd_p1_preempt_cnt_r;
  logic        dcd_p1_preempt_s;

  assign dcd_p1_preempt_s = bus.dcd_reg_file_rd_p1_req & aux_on_p1_s & (state_r == ST_STARVED);

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aux_stall_cnt_r      <= 16'd0;
      dcd_p1_preempt_cnt_r <= 16'd0;
    end else begin
      if (aux_lose_s && (aux_stall_cnt_r != 16'hFFFF)) begin
        aux_stall_cnt_r <= aux_stall_cnt_r + 16'd1;
      end
      if (dcd_p1_preempt_s && (dcd_p1_preempt_cnt_r != 16'hFFFF)) begin
        dcd_p1_preempt_cnt_r <= dcd_p1_preempt_cnt_r + 16'd1;
      end
    end
  end

  assign bus.aux_stall_cnt      = aux_stall_cnt_r;
  assign bus.dcd_p1_preempt_cnt = dcd_p1_preempt_cnt_r;
`endif

endmodule

// File: tb/tb_panda_risc_v_reg_file_rd_arb.sv
// Directed self-checking bench for panda_risc_v_reg_file_rd_arb (STARVE_TH = 4).
module tb_panda_risc_v_reg_file_rd_arb;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  int   n_fail;

  panda_risc_v_reg_file_rd_arb_if bus ();

  panda_risc_v_reg_file_rd_arb #(
    .simulation_delay(1),
    .STARVE_TH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of requests just after the falling edge, then let combinational outputs settle.
  task automatic drive(input logic p0r, input logic [4:0] p0a, input logic p1r, input logic [4:0] p1a,
                       input logic ar, input logic [4:0] aa);
    @(negedge clk);
    bus.dcd_reg_file_rd_p0_req  = p0r;
    bus.dcd_reg_file_rd_p0_addr = p0a;
    bus.dcd_reg_file_rd_p1_req  = p1r;
    bus.dcd_reg_file_rd_p1_addr = p1a;
    bus.aux_reg_file_rd_req     = ar;
    bus.aux_reg_file_rd_addr    = aa;
    #1;
  endtask

  task automatic chk_grants(input string tag, input logic g0, input logic g1, input logic ga);
    chk({tag, "_p0_grant"}, 32'(bus.dcd_reg_file_rd_p0_grant), 32'(g0));
    chk({tag, "_p1_grant"}, 32'(bus.dcd_reg_file_rd_p1_grant), 32'(g1));
    chk({tag, "_aux_grant"}, 32'(bus.aux_reg_file_rd_grant), 32'(ga));
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    n_fail  = 0;
    rst     = 1'b1;
    bus.dcd_reg_file_rd_p0_req  = 1'b0;
    bus.dcd_reg_file_rd_p0_addr = 5'd0;
    bus.dcd_reg_file_rd_p1_req  = 1'b0;
    bus.dcd_reg_file_rd_p1_addr = 5'd0;
    bus.aux_reg_file_rd_req     = 1'b0;
    bus.aux_reg_file_rd_addr    = 5'd0;
    bus.reg_file_rd_p0_dout     = 32'h1234_5678;
    bus.reg_file_rd_p1_dout     = 32'hCAFE_0001;

    // Reset: all requesting, nothing granted
    drive(1'b1, 5'd3, 1'b1, 5'd12, 1'b1, 5'd9);
    chk_grants("reset", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Aux alone takes port 0
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7);
    chk_grants("aux_only", 1'b0, 1'b0, 1'b1);
    chk("aux_only_rf_p0_addr", 32'(bus.reg_file_rd_p0_addr), 32'd7);
    chk("aux_only_dout", bus.aux_reg_file_rd_dout, 32'h1234_5678);

    // dcd p0 busy, p1 idle: aux on port 1
    drive(1'b1, 5'd3, 1'b0, 5'd12, 1'b1, 5'd9);
    chk_grants("p0_busy", 1'b1, 1'b0, 1'b1);
    chk("p0_busy_rf_p0_addr", 32'(bus.reg_file_rd_p0_addr), 32'd3);
    chk("p0_busy_rf_p1_addr", 32'(bus.reg_file_rd_p1_addr), 32'd9);
    chk("p0_busy_p0_dout", bus.dcd_reg_file_rd_p0_dout, 32'h1234_5678);
    chk("p0_busy_aux_dout", bus.aux_reg_file_rd_dout, 32'hCAFE_0001);

    // dcd p1 busy, p0 idle: aux on port 0
    drive(1'b0, 5'd4, 1'b1, 5'd12, 1'b1, 5'd9);
    chk_grants("p1_busy", 1'b0, 1'b1, 1'b1);
    chk("p1_busy_rf_p0_addr", 32'(bus.reg_file_rd_p0_addr), 32'd9);
    chk("p1_busy_rf_p1_addr", 32'(bus.reg_file_rd_p1_addr), 32'd12);
    chk("p1_busy_p1_dout", bus.dcd_reg_file_rd_p1_dout, 32'hCAFE_0001);

    // Full load: aux waits 4 cycles, forced on the 5th
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd3, 1'b1, 5'd12, 1'b1, 5'd9);
      chk_grants("full_wait", 1'b1, 1'b1, 1'b0);
      chk("full_wait_rf_p1_addr", 32'(bus.reg_file_rd_p1_addr), 32'd12);
    end
    drive(1'b1, 5'd3, 1'b1, 5'd12, 1'b1, 5'd9);
    chk_grants("forced", 1'b1, 1'b0, 1'b1);
    chk("forced_rf_p1_addr", 32'(bus.reg_file_rd_p1_addr), 32'd9);
    chk("forced_rf_p0_addr", 32'(bus.reg_file_rd_p0_addr), 32'd3);
    chk("forced_aux_dout", bus.aux_reg_file_rd_dout, 32'hCAFE_0001);
    drive(1'b1, 5'd3, 1'b1, 5'd12, 1'b0, 5'd9);
    chk_grants("after_forced", 1'b1, 1'b1, 1'b0);
`ifdef REG_FILE_RD_ARB_STAT_EN
    chk("stat_stall", 32'(bus.aux_stall_cnt), 32'd4);
    chk("stat_preempt", 32'(bus.dcd_p1_preempt_cnt), 32'd1);
`endif

    // Wait 2, drop 1, re-assert: counter restarts
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 5'd3, 1'b1, 5'd12, 1'b1, 5'd9);
      chk_grants("pre_drop", 1'b1, 1'b1, 1'b0);
    end
    drive(1'b1, 5'd3, 1'b1, 5'd12, 1'b0, 5'd9);
    chk_grants("drop", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd3, 1'b1, 5'd12, 1'b1, 5'd9);
      chk_grants("restart_wait", 1'b1, 1'b1, 1'b0);
    end
    drive(1'b1, 5'd3, 1'b1, 5'd12, 1'b1, 5'd9);
    chk_grants("restart_forced", 1'b1, 1'b0, 1'b1);
    drive(1'b1, 5'd3, 1'b1, 5'd12, 1'b0, 5'd9);

    // Reset asserted while STARVED
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd3, 1'b1, 5'd12, 1'b1, 5'd9);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_grants("rst_starved", 1'b0, 1'b0, 1'b0);
`ifdef REG_FILE_RD_ARB_STAT_EN
    chk("rst_stat_stall", 32'(bus.aux_stall_cnt), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd3, 1'b1, 5'd12, 1'b1, 5'd9);
      chk_grants("post_rst_wait", 1'b1, 1'b1, 1'b0);
    end
    drive(1'b1, 5'd3, 1'b1, 5'd12, 1'b1, 5'd9);
    chk_grants("post_rst_forced", 1'b1, 1'b0, 1'b1);
    drive(1'b1, 5'd3, 1'b1, 5'd12, 1'b0, 5'd9);

    // STARVED with aux dropped: dcd p1 served, then counting restarts from 0
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd3, 1'b1, 5'd12, 1'b1, 5'd9);
    end
    drive(1'b1, 5'd3, 1'b1, 5'd12, 1'b0, 5'd9);
    chk_grants("starved_noreq", 1'b1, 1'b1, 1'b0);
    chk("starved_noreq_rf_p1_addr", 32'(bus.reg_file_rd_p1_addr), 32'd12);
    drive(1'b1, 5'd3, 1'b1, 5'd12, 1'b1, 5'd9);
    chk_grants("starved_rearm", 1'b1, 1'b1, 1'b0);
    drive(1'b0, 5'd3, 1'b0, 5'd12, 1'b0, 5'd9);
`ifdef REG_FILE_RD_ARB_STAT_EN
    chk("final_stat_stall", 32'(bus.aux_stall_cnt), 32'd9);
    chk("final_stat_preempt", 32'(bus.dcd_p1_preempt_cnt), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
